// File: rtl/bist_pkg.sv
// Shared definitions for the BIST sequencer and the downstream state decoder.
// Holds the 5-bit state code width, the numeric state codes and the widths of
// the sequencer's internal counters.
package bist_pkg;

  localparam int CODE_W   = 5;
  localparam int SETTLE_W = 4;
  localparam int ERR_W    = 8;
  localparam int WD_W     = 12;

  localparam logic [CODE_W-1:0] ST_STATE0    = 5'd0;
  localparam logic [CODE_W-1:0] ST_STATE1    = 5'd1;
  localparam logic [CODE_W-1:0] ST_STATE1_1  = 5'd2;
  localparam logic [CODE_W-1:0] ST_STATE1_2  = 5'd3;
  localparam logic [CODE_W-1:0] ST_STATE2    = 5'd4;
  localparam logic [CODE_W-1:0] ST_STATE2_1  = 5'd5;
  localparam logic [CODE_W-1:0] ST_STATE2_2  = 5'd6;
  localparam logic [CODE_W-1:0] ST_STATE2_3  = 5'd7;
  localparam logic [CODE_W-1:0] ST_LOGIC_RES = 5'd8;
  localparam logic [CODE_W-1:0] ST_STATE2_4  = 5'd9;
  localparam logic [CODE_W-1:0] ST_STATE2_5  = 5'd10;
  localparam logic [CODE_W-1:0] ST_STATE2_6  = 5'd11;
  localparam logic [CODE_W-1:0] ST_STATE2_7  = 5'd12;
  localparam logic [CODE_W-1:0] ST_STATE2_8  = 5'd13;
  localparam logic [CODE_W-1:0] ST_STATE2_9  = 5'd14;
  localparam logic [CODE_W-1:0] ST_STATE3    = 5'd15;
  localparam logic [CODE_W-1:0] ST_STATE4    = 5'd16;

  // Codes 17..31 are not listed and are treated as illegal.
  typedef enum logic [CODE_W-1:0] {
    S_STATE0    = ST_STATE0,
    S_STATE1    = ST_STATE1,
    S_STATE1_1  = ST_STATE1_1,
    S_STATE1_2  = ST_STATE1_2,
    S_STATE2    = ST_STATE2,
    S_STATE2_1  = ST_STATE2_1,
    S_STATE2_2  = ST_STATE2_2,
    S_STATE2_3  = ST_STATE2_3,
    S_LOGIC_RES = ST_LOGIC_RES,
    S_STATE2_4  = ST_STATE2_4,
    S_STATE2_5  = ST_STATE2_5,
    S_STATE2_6  = ST_STATE2_6,
    S_STATE2_7  = ST_STATE2_7,
    S_STATE2_8  = ST_STATE2_8,
    S_STATE2_9  = ST_STATE2_9,
    S_STATE3    = ST_STATE3,
    S_STATE4    = ST_STATE4
  } bist_state_e;

endpackage

// File: rtl/bist_fsm_sequencer_if.sv
// Bundle of the BIST sequencer's handshake and status signals.
//   master : side that requests a pass and watches status (controller / bench)
//   slave  : sequencer side
//   start, abort, counter_last, cmp_err : requests and datapath feedback
//   code, busy, done, err_cnt, timeout  : sequencer status
interface bist_fsm_sequencer_if;
  logic                        start;
  logic                        abort;
  logic                        counter_last;
  logic                        cmp_err;
  logic [bist_pkg::CODE_W-1:0] code;
  logic                        busy;
  logic                        done;
  logic [bist_pkg::ERR_W-1:0]  err_cnt;
  logic                        timeout;

  modport master (
    output start, abort, counter_last, cmp_err,
    input  code, busy, done, err_cnt, timeout
  );

  modport slave (
    input  start, abort, counter_last, cmp_err,
    output code, busy, done, err_cnt, timeout
  );
endinterface

// File: rtl/bist_watchdog.sv
// Pass watchdog for the BIST sequencer (only instantiated with BIST_TIMEOUT_EN).
//   clk, rst : clock, asynchronous active-high reset
//   busy     : count enable, one count per busy cycle (saturates at all-ones)
//   clr      : sequencer idle, counter held at zero
//   arm      : new pass starting, clears the sticky flag
//   expire   : counter equals LIMIT this cycle
//   timeout  : sticky flag, set on expire
module bist_watchdog
  import bist_pkg::*;
#(
  parameter int LIMIT = 4095
) (
  input  logic clk,
  input  logic rst,
  input  logic busy,
  input  logic clr,
  input  logic arm,
  output logic expire,
  output logic timeout
);

  logic [WD_W-1:0] cnt_q, cnt_d;
  logic            timeout_q, timeout_d;

  assign expire  = (cnt_q == WD_W'(LIMIT));
  assign timeout = timeout_q;

  always_comb begin
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    if (clr) begin
      cnt_d = '0;
    end else if (busy && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (arm) begin
      timeout_d = 1'b0;
    end
    if (expire) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

endmodule

// File: rtl/bist_fsm_sequencer.sv
// BIST sequencer: fills memory, then runs a compare loop per address and
// counts mismatches. The registered state code drives an external decoder.
//   BIST_clk, BIST_res : clock, asynchronous active-high reset
//   BIST_start         : level request for one pass (held high keeps state4)
//   BIST_abort         : stop the pass, go through state3 to state4
//   Counter_last       : address counter at final value
//   Cmp_err            : response mismatch, valid in state2_7
//   BIST_CODE          : current state code (5 bits)
//   BIST_busy/done     : pass running / pass finished (state4)
//   Err_cnt            : saturating mismatch count for the current pass
//   BIST_timeout       : sticky watchdog flag
// Optional feature: define BIST_TIMEOUT_EN to add the pass watchdog; without
// it BIST_timeout is constant 0 and no watchdog logic is built.
module bist_fsm_sequencer
  import bist_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 4095
) (
  input  logic              BIST_clk,
  input  logic              BIST_res,
  input  logic              BIST_start,
  input  logic              BIST_abort,
  input  logic              Counter_last,
  input  logic              Cmp_err,
  output logic [CODE_W-1:0] BIST_CODE,
  output logic              BIST_busy,
  output logic              BIST_done,
  output logic [ERR_W-1:0]  Err_cnt,
  output logic              BIST_timeout
);

  // Counter is loaded with N-1 so state2_6 lasts exactly N cycles.
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);

  bist_state_e          state_q, state_d;
  logic [SETTLE_W-1:0]  settle_q, settle_d;
  logic [ERR_W-1:0]     err_cnt_q, err_cnt_d;
  logic                 abortable;
  logic                 pass_start;
  logic                 wd_expire;
  logic                 force_stop;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  assign BIST_CODE  = state_q;
  assign BIST_busy  = (state_q != S_STATE0) && (state_q != S_STATE4);
  assign BIST_done  = (state_q == S_STATE4);
  assign Err_cnt    = err_cnt_q;
  assign abortable  = !(state_q inside {S_STATE0, S_STATE3, S_STATE4});
  assign pass_start = (state_q == S_STATE0) && BIST_start;

`ifdef BIST_TIMEOUT_EN
  bist_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (BIST_clk),
    .rst     (BIST_res),
    .busy    (BIST_busy),
    .clr     (state_q == S_STATE0),
    .arm     (pass_start),
    .expire  (wd_expire),
    .timeout (BIST_timeout)
  );
`else
  assign wd_expire    = 1'b0;
  assign BIST_timeout = 1'b0;
`endif

  // Abort and watchdog expiry share the same top priority.
  assign force_stop = abortable && (BIST_abort || wd_expire);

  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    err_cnt_d = err_cnt_q;
    case (state_q)
      S_STATE0: begin
        if (BIST_start) begin
          state_d   = S_STATE1;
          err_cnt_d = '0;
        end
      end
      S_STATE1:    state_d = S_STATE1_1;
      S_STATE1_1:  state_d = S_STATE1_2;
      S_STATE1_2:  state_d = Counter_last ? S_STATE2 : S_STATE1_1;
      S_STATE2:    state_d = S_STATE2_1;
      S_STATE2_1:  state_d = S_STATE2_2;
      S_STATE2_2:  state_d = S_STATE2_3;
      S_STATE2_3:  state_d = S_LOGIC_RES;
      S_LOGIC_RES: state_d = S_STATE2_4;
      S_STATE2_4:  state_d = S_STATE2_5;
      S_STATE2_5: begin
        state_d  = S_STATE2_6;
        settle_d = SETTLE_LOAD;
      end
      S_STATE2_6: begin
        if (settle_q == '0) begin
          state_d = S_STATE2_7;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end
      S_STATE2_7: begin
        if (Cmp_err) begin
          state_d = S_STATE2_8;
        end else begin
          state_d = Counter_last ? S_STATE2_9 : S_STATE2_1;
        end
      end
      S_STATE2_8: begin
        err_cnt_d = sat_inc(err_cnt_q);
        state_d   = Counter_last ? S_STATE2_9 : S_STATE2_1;
      end
      S_STATE2_9:  state_d = S_STATE3;
      S_STATE3:    state_d = S_STATE4;
      S_STATE4:    state_d = BIST_start ? S_STATE4 : S_STATE0;
      // Illegal codes clean up through state3.
      default:     state_d = S_STATE3;
    endcase
    if (force_stop) begin
      state_d = S_STATE3;
    end
  end

  always_ff @(posedge BIST_clk or posedge BIST_res) begin
    if (BIST_res) begin
      state_q   <= S_STATE0;
      settle_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      err_cnt_q <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_bist_fsm_sequencer.sv
`timescale 1ns/1ps
module tb_bist_fsm_sequencer;

  localparam int SETTLE = 3;
  localparam int TMO    = 4095;
`ifdef BIST_TIMEOUT_EN
  localparam bit WD_ON = 1'b1;
`else
  localparam bit WD_ON = 1'b0;
`endif
  localparam int M_HOLD = 0;
  localparam int M_PLAN = 1;
  localparam int M_RAND = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bist_fsm_sequencer_if bif ();

  bist_fsm_sequencer #(
    .SETTLE_CYCLES  (SETTLE),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .BIST_clk     (clk),
    .BIST_res     (rst),
    .BIST_start   (bif.start),
    .BIST_abort   (bif.abort),
    .Counter_last (bif.counter_last),
    .Cmp_err      (bif.cmp_err),
    .BIST_CODE    (bif.code),
    .BIST_busy    (bif.busy),
    .BIST_done    (bif.done),
    .Err_cnt      (bif.err_cnt),
    .BIST_timeout (bif.timeout)
  );

`ifdef BIST_TIMEOUT_EN
  logic [4:0] wd_code;
  logic       wd_busy, wd_done, wd_to;
  logic [7:0] wd_err;
  bist_fsm_sequencer #(
    .SETTLE_CYCLES  (2),
    .TIMEOUT_CYCLES (50)
  ) dut_wd (
    .BIST_clk     (clk),
    .BIST_res     (rst),
    .BIST_start   (bif.start),
    .BIST_abort   (bif.abort),
    .Counter_last (bif.counter_last),
    .Cmp_err      (bif.cmp_err),
    .BIST_CODE    (wd_code),
    .BIST_busy    (wd_busy),
    .BIST_done    (wd_done),
    .Err_cnt      (wd_err),
    .BIST_timeout (wd_to)
  );
`endif

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_code  = 0;
  int m_err   = 0;
  int m_dwell = 0;
  int m_wd    = 0;
  bit m_to    = 1'b0;
  int m_addr  = 0;

  function automatic bit m_busy(input int c);
    return !(c == 0 || c == 16);
  endfunction

  // Next state code from the sequencing rules; the straight-line parts of
  // both loops are simply "code + 1".
  function automatic int model_next(input int code, input bit start, input bit abort,
                                    input bit last, input bit cerr, input bit expire,
                                    input int dwell);
    if ((abort || expire) && !(code == 0 || code == 15 || code == 16)) return 15;
    case (code)
      0:       return start ? 1 : 0;
      3:       return last ? 4 : 2;
      11:      return (dwell >= SETTLE) ? 12 : 11;
      12:      return cerr ? 13 : (last ? 14 : 5);
      13:      return last ? 14 : 5;
      16:      return start ? 16 : 0;
      default: return code + 1;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_code = 0; m_err = 0; m_dwell = 0; m_wd = 0; m_to = 1'b0; m_addr = 0;
    end else begin
      int  nxt;
      bit  expire;
      expire = WD_ON && (m_wd == TMO);
      nxt = model_next(m_code, bif.start, bif.abort, bif.counter_last, bif.cmp_err,
                       expire, m_dwell);
      if (m_code == 0 && nxt == 1) begin
        m_err = 0;
        m_to  = 1'b0;
      end
      if (m_code == 13) m_err++;
      if (expire) m_to = 1'b1;
      if (m_code == 0) m_wd = 0;
      else if (m_busy(m_code) && m_wd < 4095) m_wd++;
      // Emulated address counter feeding Counter_last / Cmp_err plans.
      if (nxt == 1 || (m_code == 3 && nxt == 4)) m_addr = 0;
      else if (m_code == 3 && nxt == 2) m_addr++;
      else if ((m_code == 12 || m_code == 13) && nxt == 5) m_addr++;
      m_dwell = (nxt == 11) ? ((m_code == 11) ? m_dwell + 1 : 1) : 0;
      m_code = nxt;
    end
  end

  // ---------------- per-cycle compare ----------------
  bit chk_on   = 1'b0;
  int run11    = 0;
  int dut_v13  = 0;

  always @(negedge clk) begin
    if (chk_on) begin
      check("code", bif.code, m_code);
      check("busy", bif.busy, m_busy(m_code));
      check("done", bif.done, (m_code == 16));
      check("err_cnt", bif.err_cnt, (m_err > 255) ? 255 : m_err);
      check("timeout", bif.timeout, WD_ON ? m_to : 1'b0);
      if (bif.code == 5'd11) run11++;
      else begin
        if (run11 != 0 && bif.code == 5'd12) check("settle_len", run11, SETTLE);
        run11 = 0;
      end
      if (bif.code == 5'd13) dut_v13++;
    end
  end

  // ---------------- stimulus ----------------
  int        mode     = M_HOLD;
  int        plan_n   = 4;
  bit [31:0] plan_mask = '0;
  bit        plan_all = 1'b0;

  task automatic apply_inputs();
    if (mode == M_PLAN) begin
      bif.counter_last = (m_addr == plan_n - 1);
      bif.cmp_err      = plan_all ? 1'b1 : ((m_addr < 32) ? plan_mask[m_addr] : 1'b0);
    end else if (mode == M_RAND) begin
      bif.counter_last = ($urandom_range(0, 3) == 0);
      bif.cmp_err      = $urandom_range(0, 1) != 0;
      bif.abort        = ($urandom_range(0, 49) == 0);
      if (m_code == 0 || m_code == 16) bif.start = $urandom_range(0, 2) != 0;
      else bif.start = $urandom_range(0, 1) != 0;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    apply_inputs();
  endtask

  task automatic wait_code(input int target, input int budget, input string name);
    int k = 0;
    while (bif.code !== target[4:0] && k < budget) begin
      cyc();
      k++;
    end
    check(name, bif.code, target);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, n_chk=%0d", n_chk);
    $fatal(1, "global timeout");
  end

  initial begin
    int exp_fill[10] = '{1, 2, 3, 2, 3, 2, 3, 2, 3, 4};
    rst = 1'b0;
    bif.start = 1'b0; bif.abort = 1'b0; bif.counter_last = 1'b0; bif.cmp_err = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_on = 1'b1;
    check("rst_code", bif.code, 0);
    check("rst_busy", bif.busy, 0);
    check("rst_done", bif.done, 0);
    check("rst_err", bif.err_cnt, 0);
    check("rst_timeout", bif.timeout, 0);
    rst = 1'b0;

    // Four-address pass, no mismatches.
    mode = M_PLAN; plan_n = 4; plan_mask = '0; plan_all = 1'b0;
    bif.start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("fill_seq", bif.code, exp_fill[i]);
    end
    wait_code(16, 200, "pass1_end");
    check("pass1_err", bif.err_cnt, 0);
    check("pass1_done", bif.done, 1);
    bif.start = 1'b0;
    cyc();
    check("pass1_idle", bif.code, 0);

    // Mismatches on iterations 0 and 2.
    plan_mask = 32'h5; dut_v13 = 0;
    bif.start = 1'b1;
    wait_code(16, 300, "pass2_end");
    check("visits_13", dut_v13, 2);
    check("pass2_err", bif.err_cnt, 2);
    bif.start = 1'b0;
    cyc();

    // 300 mismatches saturate the counter.
    plan_n = 300; plan_all = 1'b1;
    bif.start = 1'b1;
    wait_code(16, 5000, "pass3_end");
    check("err_sat", bif.err_cnt, 255);
    bif.start = 1'b0;
    cyc();

    // Abort during settle.
    plan_n = 4; plan_all = 1'b0; plan_mask = '0;
    bif.start = 1'b1;
    wait_code(11, 100, "reach_settle");
    bif.abort = 1'b1;
    cyc();
    bif.abort = 1'b0;
    check("abort_s3", bif.code, 15);
    cyc();
    check("abort_s4", bif.code, 16);
    bif.start = 1'b0;
    cyc();
    check("abort_idle", bif.code, 0);

    // Asynchronous reset in the middle of a pass with errors counted.
    plan_all = 1'b1;
    bif.start = 1'b1;
    wait_code(13, 200, "reach_err");
    cyc();
    cyc();
    #3 rst = 1'b1;
    #1;
    check("arst_code", bif.code, 0);
    check("arst_busy", bif.busy, 0);
    check("arst_done", bif.done, 0);
    check("arst_err", bif.err_cnt, 0);
    check("arst_timeout", bif.timeout, 0);
    bif.start = 1'b0;
    plan_all = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    cyc();
    check("arst_hold", bif.code, 0);

    // Randomized traffic against the model.
    mode = M_RAND;
    repeat (3000) cyc();
    mode = M_HOLD;
    bif.start = 1'b0; bif.abort = 1'b0; bif.counter_last = 1'b1; bif.cmp_err = 1'b0;
    wait_code(0, 200, "rand_drain");

`ifdef BIST_TIMEOUT_EN
    begin
      int k;
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      bif.counter_last = 1'b0;
      bif.start = 1'b1;
      cyc();
      k = 1;
      while (wd_to !== 1'b1 && k < 200) begin
        cyc();
        k++;
      end
      check("wd_edges", k, 52);
      check("wd_code_s3", wd_code, 15);
      cyc();
      check("wd_code_s4", wd_code, 16);
      check("wd_sticky", wd_to, 1);
      bif.start = 1'b0;
      cyc();
      check("wd_idle", wd_code, 0);
      check("wd_sticky_idle", wd_to, 1);
      bif.start = 1'b1;
      cyc();
      check("wd_rearm_code", wd_code, 1);
      check("wd_rearm_clear", wd_to, 0);
      bif.start = 1'b0;
      bif.counter_last = 1'b1;
    end
`endif

    repeat (2) cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
